// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: N valid/ready requesters share one FIFO write port,
// each grant holds for up to BURST beats, and every beat is tagged with its requester index.
module fifo_wr_arbiter #(
  parameter int N     = 4,
  parameter int W     = 10,
  parameter int TW    = 2,
  parameter int D     = 2,
  parameter int BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  input  logic [N*W-1:0]    req_data,
  output logic [N-1:0]      req_ready,
  input  logic [N-1:0]      en_mask,
  output logic              fifo_wr,
  output logic [TW+W-1:0]   fifo_wrdata,
  input  logic              fifo_full,
  input  logic [D:0]        fifo_data_count,
  output logic [TW-1:0]     grant_id,
  output logic              busy,
  output logic [15:0]       stall_cnt
);

  localparam int BW = $clog2(BURST + 1);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   grant_q, grant_d;
  logic [TW-1:0]   last_q, last_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [15:0]     stall_q, stall_d;
  logic [TW+W-1:0] wrdata_q, wrdata_d;

  logic [N-1:0]    cand_s;
  logic [N-1:0]    ready_s;
  logic            full_s;
  logic            found_s;
  logic [TW-1:0]   win_s;
  logic            xfer_s;

  // Next-state, winner search and combinational write handshake
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    beat_d   = beat_q;
    stall_d  = stall_q;
    wrdata_d = wrdata_q;
    ready_s  = '0;
    found_s  = 1'b0;
    win_s    = '0;
    xfer_s   = 1'b0;
    cand_s   = req_valid & en_mask;
    // an occupancy at full depth blocks writes even if the flag lags
    full_s   = fifo_full | (fifo_data_count >= (D+1)'(2**D));

    case (state_q)
      S_IDLE: begin
        // k runs 1..N so the previous winner is considered last
        for (int k = 1; k <= N; k++) begin
          if (!found_s && cand_s[(int'(last_q) + k) % N]) begin
            found_s = 1'b1;
            win_s   = TW'((int'(last_q) + k) % N);
          end
        end
        if (found_s) begin
          grant_d = win_s;
          beat_d  = '0;
          state_d = S_BURST;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BURST: begin
        ready_s[grant_q] = ~full_s & en_mask[grant_q];
        xfer_s           = req_valid[grant_q] & ready_s[grant_q];
        if (xfer_s) begin
          wrdata_d = {grant_q, req_data[int'(grant_q)*W +: W]};
          beat_d   = beat_q + BW'(1);
        end else begin
          wrdata_d = wrdata_q;
        end
        if ((xfer_s && (beat_q == BW'(BURST - 1))) || !req_valid[grant_q] || !en_mask[grant_q]) begin
          state_d = S_IDLE;
          last_d  = grant_q;
        end else begin
          state_d = S_BURST;
        end
        if (req_valid[grant_q] && full_s && (stall_q != 16'hFFFF)) begin
          stall_d = stall_q + 16'd1;
        end else begin
          stall_d = stall_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      last_q   <= TW'(N - 1);
      beat_q   <= '0;
      stall_q  <= 16'd0;
      wrdata_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      beat_q   <= beat_d;
      stall_q  <= stall_d;
      wrdata_q <= wrdata_d;
    end
  end

  // Handshake is suppressed while reset is held so nothing is written in that cycle
  assign req_ready   = rst ? '0 : ready_s;
  assign fifo_wr     = xfer_s & ~rst;
  assign fifo_wrdata = fifo_wr ? wrdata_d : wrdata_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q == S_BURST);
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: models requester streams and a depth-4 FIFO
// and checks logged writes against hand-computed tag/data sequences.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 10;
  localparam int TW = 2;
  localparam int D  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*W-1:0]    req_data;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      en_mask;
  logic              fifo_wr;
  logic [TW+W-1:0]   fifo_wrdata;
  logic              fifo_full;
  logic [D:0]        fifo_data_count;
  logic [TW-1:0]     grant_id;
  logic              busy;
  logic [15:0]       stall_cnt;

  fifo_wr_arbiter #(.N(N), .W(W), .TW(TW), .D(D), .BURST(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .en_mask         (en_mask),
    .fifo_wr         (fifo_wr),
    .fifo_wrdata     (fifo_wrdata),
    .fifo_full       (fifo_full),
    .fifo_data_count (fifo_data_count),
    .grant_id        (grant_id),
    .busy            (busy),
    .stall_cnt       (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0]    src_mem [N][16];
  int              src_len [N];
  int              src_pos [N];
  int              fcount;
  bit              reader_on;
  logic [TW+W-1:0] wlog [$];
  int              wcyc [$];
  int              cyc = 0;
  logic [N-1:0]    ready_seen;
  bit              wr_full_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]         = (src_pos[i] < src_len[i]);
      req_data[i*W +: W]   = req_valid[i] ? src_mem[i][src_pos[i]] : '0;
    end
    fifo_full       = (fcount >= 4);
    fifo_data_count = (D+1)'(fcount);
  endtask

  task automatic tick();
    int pre;
    drive();
    #1;
    ready_seen = ready_seen | req_ready;
    if (fifo_wr && fifo_full) wr_full_seen = 1'b1;
    if (fifo_wr) begin
      wlog.push_back(fifo_wrdata);
      wcyc.push_back(cyc);
    end
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && req_ready[i]) src_pos[i]++;
    end
    pre = fcount;
    if (fifo_wr) fcount++;
    if (reader_on && pre > 0) fcount--;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic load(input int i, input int base, input int n);
    for (int k = 0; k < n; k++) src_mem[i][k] = W'(base + k + 1);
    src_pos[i] = 0;
    src_len[i] = n;
  endtask

  task automatic clear_log();
    wlog.delete();
    wcyc.delete();
    ready_seen = '0;
  endtask

  task automatic reset_dut();
    for (int i = 0; i < N; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
    fcount = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_log();
  endtask

  task automatic run_until(input string tag, input int n, input int bound);
    int c = 0;
    while (wlog.size() < n && c < bound) begin
      tick();
      c++;
    end
    check_eq(tag, wlog.size(), n);
  endtask

  task automatic exp_w(input string tag, input int idx, input int t, input int d);
    logic [31:0] e;
    e = (t << W) | d;
    check_eq(tag, (idx < wlog.size()) ? {20'd0, wlog[idx]} : 32'hDEAD_BEEF, e);
  endtask

  initial begin
    int c0;
    rst       = 1'b1;
    en_mask   = 4'hF;
    reader_on = 1'b1;
    fcount    = 0;
    for (int i = 0; i < N; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
    ready_seen = '0;
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    drive();
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_grant", grant_id, 0);
    check_eq("rst_stall", stall_cnt, 0);
    check_eq("rst_wr", fifo_wr, 0);
    check_eq("rst_wrdata", fifo_wrdata, 0);
    check_eq("rst_ready", req_ready, 0);

    // 1: single requester, 6 beats, burst split 4 + 2 with one idle cycle
    reset_dut();
    c0 = cyc;
    load(0, 0, 6);
    run_until("t1_count", 6, 40);
    for (int k = 0; k < 6; k++) exp_w($sformatf("t1_w%0d", k), k, 0, k + 1);
    check_eq("t1_first_lat", wcyc[0] - c0, 1);
    check_eq("t1_burst_span", wcyc[3] - wcyc[0], 3);
    check_eq("t1_idle_gap", wcyc[4] - wcyc[3], 2);
    check_eq("t1_tail", wcyc[5] - wcyc[4], 1);

    // 2: all four streaming, expect 0,1,2,3 rotation of 4-beat bursts
    reset_dut();
    for (int r = 0; r < N; r++) load(r, r * 64, 8);
    run_until("t2_count", 32, 200);
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < 4; k++)
        exp_w($sformatf("t2_b%0d_k%0d", b, k), b * 4 + k, b % 4, (b % 4) * 64 + (b / 4) * 4 + k + 1);

    // 3: reader off, FIFO fills, grant held while stalled, resumes after drain
    reset_dut();
    reader_on = 1'b0;
    load(1, 64, 8);
    for (int k = 0; k < 11; k++) tick();
    drive();
    #1;
    check_eq("t3_stall", stall_cnt, 5);
    check_eq("t3_busy", busy, 1);
    check_eq("t3_grant", grant_id, 1);
    check_eq("t3_ready", req_ready, 0);
    check_eq("t3_wr", fifo_wr, 0);
    check_eq("t3_pre_count", wlog.size(), 4);
    reader_on = 1'b1;
    run_until("t3_count", 8, 40);
    for (int k = 0; k < 8; k++) exp_w($sformatf("t3_w%0d", k), k, 1, 64 + k + 1);

    // 4a: req2 drops valid after 2 beats, req3 valid -> req3 next
    reset_dut();
    load(2, 128, 2);
    tick();
    tick();
    load(3, 192, 2);
    load(0, 0, 2);
    run_until("t4a_count", 6, 40);
    exp_w("t4a_w0", 0, 2, 129);
    exp_w("t4a_w1", 1, 2, 130);
    exp_w("t4a_w2", 2, 3, 193);
    exp_w("t4a_w3", 3, 3, 194);
    exp_w("t4a_w4", 4, 0, 1);
    exp_w("t4a_w5", 5, 0, 2);

    // 4b: req3 idle -> search wraps to req0 ahead of req1
    reset_dut();
    load(2, 128, 2);
    tick();
    tick();
    load(0, 0, 2);
    load(1, 64, 2);
    run_until("t4b_count", 6, 40);
    exp_w("t4b_w2", 2, 0, 1);
    exp_w("t4b_w3", 3, 0, 2);
    exp_w("t4b_w4", 4, 1, 65);
    exp_w("t4b_w5", 5, 1, 66);

    // 5: enable mask 1010 -> grants alternate 1,3
    reset_dut();
    en_mask = 4'b1010;
    for (int r = 0; r < N; r++) load(r, r * 64, 8);
    run_until("t5_count", 16, 120);
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 4; k++)
        exp_w($sformatf("t5_b%0d_k%0d", b, k), b * 4 + k, (b % 2) ? 3 : 1,
              ((b % 2) ? 3 : 1) * 64 + (b / 2) * 4 + k + 1);
    check_eq("t5_masked_ready", ready_seen & 4'b0101, 0);
    en_mask = 4'hF;

    // 6: reset mid-burst aborts and restores reset values
    reset_dut();
    reader_on = 1'b0;
    load(1, 64, 8);
    for (int k = 0; k < 8; k++) tick();
    drive();
    #1;
    check_eq("t6_pre_stall", stall_cnt, 2);
    check_eq("t6_pre_busy", busy, 1);
    fcount    = 0;
    reader_on = 1'b1;
    load(0, 0, 4);
    rst = 1'b1;
    drive();
    #1;
    check_eq("t6_rstcyc_wr", fifo_wr, 0);
    check_eq("t6_rstcyc_ready", req_ready, 0);
    tick();
    rst = 1'b0;
    drive();
    #1;
    check_eq("t6_busy", busy, 0);
    check_eq("t6_grant", grant_id, 0);
    check_eq("t6_stall", stall_cnt, 0);
    check_eq("t6_wrdata", fifo_wrdata, 0);
    check_eq("t6_ready", req_ready, 0);
    clear_log();
    run_until("t6_count", 1, 20);
    exp_w("t6_first", 0, 0, 1);

    check_eq("never_wr_full", wr_full_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
